reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of registers (2..256, need not be a power of two).
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 reads as zero and ignores writes.
REQ-004 SHALL derive localparam ADDR_W = clog2(DEPTH), minimum 1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  ADDR_W  write address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 re0, re1  input  1 each  read-request strobe, ports 0 and 1.
REQ-012 raddr0, raddr1  input  ADDR_W each  read addresses.
REQ-013 rdata0, rdata1  output  DATA_W each  registered read data.
REQ-014 rvalid0, rvalid1  output  1 each  rdataN holds the result of the request made in the previous cycle.

Function
REQ-015 Write: on a rising clk with we=1 and waddr<DEPTH, the register at waddr SHALL take wdata; it is visible to reads from the next cycle.
REQ-016 A write with waddr>=DEPTH SHALL be dropped with no state change.
REQ-017 With ZERO_REG=1, a write to address 0 SHALL be dropped.
REQ-018 Read latency SHALL be exactly 1 cycle: reN=1 at edge k gives rdataN valid and rvalidN=1 after edge k.
REQ-019 When reN=0, rvalidN SHALL go 0 at the next edge and rdataN SHALL hold its last value.
REQ-020 A read with raddrN>=DEPTH SHALL return 0 with rvalidN=1.
REQ-021 With ZERO_REG=1, a read of address 0 SHALL return 0.
REQ-022 Both ports SHALL operate independently; the same address on both ports in one cycle SHALL return identical data.
REQ-023 Same address read and written in one cycle: the result SHALL follow REQ-033/REQ-034. The ZERO_REG and out-of-range rules SHALL take precedence.
REQ-024 Back-to-back reads SHALL be allowed every cycle with no bubbles.

Reset
REQ-025 While rst=1, all registers SHALL be 0, rdata0 and rdata1 SHALL be 0, and rvalid0 and rvalid1 SHALL be 0, regardless of clk.
REQ-026 A reset asserted mid-operation SHALL abort any in-flight read (rvalid drops immediately) and any same-cycle write.
REQ-027 The first edge after rst deasserts SHALL behave as a normal cycle.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 With REG_FILE_BYPASS_EN defined, a same-cycle we=1 and reN=1 with waddr==raddrN (valid, non-zero when ZERO_REG=1) SHALL return wdata on rdataN.
REQ-034 With REG_FILE_BYPASS_EN undefined, the same case SHALL return the pre-write register contents.

Structure
REQ-029 Package reg_file_pkg SHALL hold DATA_W and DEPTH defaults, a data-word typedef and the clog2-based ADDR_W helper.
REQ-030 The N:1 selection SHALL be a sub-module reg_file_rd_mux, parametrised in DATA_W and DEPTH, combinational, with out-of-range select giving 0. It SHALL be instantiated once per read port.
REQ-031 The registered output stage, bypass compare and zero/range gating SHALL live in reg_file.

Verification
REQ-032 The bench SHALL cover:
- Reset: drive rst=1 mid-read -> rvalid0/1=0 and rdata0/1=0 immediately; reads of all addresses afterwards -> 0.
- Write/read: write 0xDEADBEEF to addr 5, then re0 raddr0=5 next cycle -> rdata0=0xDEADBEEF, rvalid0=1 one cycle later.
- Zero register: with ZERO_REG=1, write 0x12345678 to addr 0, then read addr 0 on both ports -> 0.
- Same-cycle collision: addr 3 holds 0x11111111; write 0x22222222 to addr 3 with re1 raddr1=3 in the same cycle -> 0x22222222 with REG_FILE_BYPASS_EN, 0x11111111 without it.
- Out of range: DEPTH=12; write to addr 13 then read addr 13 -> 0 and rvalid=1; addr 11 unchanged.
- Throughput: re0 held high, raddr0 stepping 1..15 per cycle after loading value i*0x01010101 at addr i -> matching data every cycle, rvalid0 stays 1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults, data-word type and address-width helper for the reg_file block.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] word_t;

  // ceil(log2(depth)), never less than 1; sized for depths up to 2**16
  function automatic int addr_w(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_rd_mux.sv
// DEPTH:1 word selector over the flattened register array; purely combinational, no backpressure.
// Selects beyond DEPTH-1 return zero.
module reg_file_rd_mux
  import reg_file_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic [DEPTH*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]       sel,
  output logic [DATA_W-1:0]       dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(sel) == i) dout = regs[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 1W/2R register file; reads registered with 1-cycle latency, a read every cycle per port, no backpressure.
// REG_FILE_BYPASS_EN forwards same-cycle write data to a matching read; otherwise pre-write contents are returned.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re0,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1
);

  logic [DEPTH*DATA_W-1:0] regs;
  logic                    wr_ok;
  logic [1:0]              re_v;
  logic [ADDR_W-1:0]       raddr_v [2];

  // out-of-range and zero-register writes never touch state
  assign wr_ok = we && (32'(waddr) < DEPTH) && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (32'(waddr) == i) regs[i*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

  assign re_v       = {re1, re0};
  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] mux_dat;
    logic [DATA_W-1:0] rd_nxt;
    logic [DATA_W-1:0] rd_q;
    logic              vld_q;
    logic              zero_rd;
    logic              hit;

    reg_file_rd_mux #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_mux (
      .regs (regs),
      .sel  (raddr_v[p]),
      .dout (mux_dat)
    );

    assign zero_rd = (32'(raddr_v[p]) >= DEPTH) || ((ZERO_REG != 0) && (raddr_v[p] == '0));

`ifdef REG_FILE_BYPASS_EN
    assign hit = wr_ok && (waddr == raddr_v[p]);
`else
    assign hit = 1'b0;
`endif

    // zero/range gating outranks forwarding
    always_comb begin
      rd_nxt = mux_dat;
      if (zero_rd) begin
        rd_nxt = '0;
      end else if (hit) begin
        rd_nxt = wdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q  <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= re_v[p];
        if (re_v[p]) rd_q <= rd_nxt;
      end
    end
  end

  assign rdata0  = g_rd[0].rd_q;
  assign rdata1  = g_rd[1].rd_q;
  assign rvalid0 = g_rd[0].vld_q;
  assign rvalid1 = g_rd[1].vld_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a default 16-entry instance and a 12-entry instance for range checks.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        we, re0, re1, rvalid0, rvalid1;
  logic [3:0]  waddr, raddr0, raddr1;
  logic [31:0] wdata, rdata0, rdata1;

  logic        b_we, b_re0, b_re1, b_rvalid0, b_rvalid1;
  logic [3:0]  b_waddr, b_raddr0, b_raddr1;
  logic [31:0] b_wdata, b_rdata0, b_rdata1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic [31:0] expb0_q [$];
  logic [31:0] expb1_q [$];

  reg_file dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .re1(re1), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1)
  );

  reg_file #(.DEPTH(12)) dut_b (
    .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re0(b_re0), .raddr0(b_raddr0), .re1(b_re1), .raddr1(b_raddr1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re0 = 1'b0; re1 = 1'b0;
    b_we = 1'b0; b_re0 = 1'b0; b_re1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e0, e1;
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold rvalid=%b%b rdata0=%h rdata1=%h required all 0", rvalid1, rvalid0, rdata0, rdata1);
    end
    rst = 1'b0;
    tick();
    we = 1'b1; waddr = 4'd2; wdata = 32'hA5A5_A5A5;
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 4'd2; exp0_q.push_back(32'hA5A5_A5A5);
    re1 = 1'b1; raddr1 = 4'd2; exp1_q.push_back(32'hA5A5_A5A5);
    tick();
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    checks++;
    if (rdata0 !== e0 || rvalid0 !== 1'b1 || rdata1 !== e1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read got %h/%b %h/%b required %h/1 %h/1", rdata0, rvalid0, rdata1, rvalid1, e0, e1);
    end
    // reads still requested; reset lands between edges
    #3 rst = 1'b1;
    #1;
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_async rvalid=%b%b rdata0=%h rdata1=%h required all 0", rvalid1, rvalid0, rdata0, rdata1);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      raddr0 = 4'(a);      exp0_q.push_back(32'h0);
      raddr1 = 4'(15 - a); exp1_q.push_back(32'h0);
      tick();
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if (rdata0 !== e0 || rvalid0 !== 1'b1 || rdata1 !== e1 || rvalid1 !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_read a=%0d got %h/%b %h/%b required 0/1 0/1", a, rdata0, rvalid0, rdata1, rvalid1);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 4'd5; exp0_q.push_back(32'hDEAD_BEEF);
    tick();
    e = exp0_q.pop_front();
    checks++;
    if (rdata0 !== e || rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL write_read got %h/%b required %h/1", rdata0, rvalid0, e);
    end
    re0 = 1'b0; raddr0 = 4'd7;
    tick();
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL idle_hold got %h/%b required deadbeef/0", rdata0, rvalid0);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e0, e1;
    we = 1'b1; waddr = 4'd0; wdata = 32'h1234_5678;
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 4'd0; exp0_q.push_back(32'h0);
    re1 = 1'b1; raddr1 = 4'd0; exp1_q.push_back(32'h0);
    tick();
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    checks++;
    if (rdata0 !== e0 || rvalid0 !== 1'b1 || rdata1 !== e1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_reg got %h/%b %h/%b required 0/1 0/1", rdata0, rvalid0, rdata1, rvalid1);
    end
    raddr0 = 4'd5; exp0_q.push_back(32'hDEAD_BEEF);
    raddr1 = 4'd5; exp1_q.push_back(32'hDEAD_BEEF);
    tick();
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    checks++;
    if (rdata0 !== e0 || rdata1 !== e1 || rvalid0 !== 1'b1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL same_addr_both got %h %h required %h %h", rdata0, rdata1, e0, e1);
    end
    idle();
  endtask

  task automatic test_collision();
    logic [31:0] e0, e1;
    we = 1'b1; waddr = 4'd3; wdata = 32'h1111_1111;
    tick();
    wdata = 32'h2222_2222;
    re1 = 1'b1; raddr1 = 4'd3;
`ifdef REG_FILE_BYPASS_EN
    exp1_q.push_back(32'h2222_2222);
`else
    exp1_q.push_back(32'h1111_1111);
`endif
    tick();
    e1 = exp1_q.pop_front();
    checks++;
    if (rdata1 !== e1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL collision got %h/%b required %h/1", rdata1, rvalid1, e1);
    end
    we = 1'b0;
    re0 = 1'b1; raddr0 = 4'd3; exp0_q.push_back(32'h2222_2222);
    exp1_q.push_back(32'h2222_2222);
    tick();
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    checks++;
    if (rdata0 !== e0 || rdata1 !== e1) begin
      errors++;
      $display("FAIL after_collision got %h %h required %h %h", rdata0, rdata1, e0, e1);
    end
    re1 = 1'b0;
    we = 1'b1; waddr = 4'd0; wdata = 32'hFFFF_FFFF;
    raddr0 = 4'd0; exp0_q.push_back(32'h0);
    tick();
    e0 = exp0_q.pop_front();
    checks++;
    if (rdata0 !== e0 || rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL collision_zero got %h/%b required 0/1", rdata0, rvalid0);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] e0, e1;
    b_we = 1'b1; b_waddr = 4'd11; b_wdata = 32'hCAFE_F00D;
    tick();
    b_waddr = 4'd13; b_wdata = 32'hBAD0_BAD0;
    b_re0 = 1'b1; b_raddr0 = 4'd13; expb0_q.push_back(32'h0);
    tick();
    e0 = expb0_q.pop_front();
    checks++;
    if (b_rdata0 !== e0 || b_rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_collision got %h/%b required 0/1", b_rdata0, b_rvalid0);
    end
    b_we = 1'b0;
    b_raddr0 = 4'd13; expb0_q.push_back(32'h0);
    b_re1 = 1'b1; b_raddr1 = 4'd11; expb1_q.push_back(32'hCAFE_F00D);
    tick();
    e0 = expb0_q.pop_front();
    e1 = expb1_q.pop_front();
    checks++;
    if (b_rdata0 !== e0 || b_rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_read got %h/%b required 0/1", b_rdata0, b_rvalid0);
    end
    checks++;
    if (b_rdata1 !== e1 || b_rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL oor_neighbour got %h/%b required %h/1", b_rdata1, b_rvalid1, e1);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wdata = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    re0 = 1'b1; re1 = 1'b1;
    for (int i = 1; i < 16; i++) begin
      raddr0 = 4'(i);      exp0_q.push_back(32'(i) * 32'h0101_0101);
      raddr1 = 4'(16 - i); exp1_q.push_back(32'(16 - i) * 32'h0101_0101);
      tick();
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if (rdata0 !== e0 || rvalid0 !== 1'b1 || rdata1 !== e1 || rvalid1 !== 1'b1) begin
        errors++;
        $display("FAIL stream i=%0d got %h/%b %h/%b required %h/1 %h/1", i, rdata0, rvalid0, rdata1, rvalid1, e0, e1);
      end
    end
    idle();
    tick();
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL stream_end got %h/%b required 0f0f0f0f/0", rdata0, rvalid0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
    b_waddr = '0; b_wdata = '0; b_raddr0 = '0; b_raddr1 = '0;
    repeat (3) tick();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
